// File: rtl/sync_fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sync_fifo_rr_arbiter
//
// Round-robin write-side arbiter sharing one sync_fifo input port among
// NUM_REQ valid/ready requesters. One requester is granted at a time for a
// burst of at most MAX_BURST beats. Beats are accepted only while the FIFO's
// registered iready threshold indication is high. Accepted beats are presented
// to the FIFO one cycle later on a registered write strobe.
//
// Parameters:
//   NUM_REQ    - number of requesters (>= 2)
//   DATA_WIDTH - beat width, equal to the FIFO data width
//   MAX_BURST  - maximum beats per grant (>= 1)
//
// Ports:
//   clk          - single clock
//   rst_n        - asynchronous active-low reset
//   req_valid    - per-requester beat valid
//   req_ready    - per-requester accept (combinational)
//   req_data     - requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_ivalid  - registered FIFO write strobe
//   fifo_idata   - registered FIFO write data
//   fifo_iready  - FIFO below-threshold indication
//   grant_id     - current or last granted requester
//   busy         - high while a grant is active
//   beat_count   - per-requester saturating 16-bit beat counters
//                  (present only when SYNC_FIFO_ARB_STATS_EN is defined)
//
// Optional feature macro: SYNC_FIFO_ARB_STATS_EN
// -----------------------------------------------------------------------------
module sync_fifo_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic                            fifo_ivalid,
    output logic [DATA_WIDTH-1:0]           fifo_idata,
    input  logic                            fifo_iready,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
`ifdef SYNC_FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]           beat_count
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [ID_W-1:0]        ptr_r;
    logic [ID_W-1:0]        grant_id_r;
    logic [CNT_W-1:0]       beat_cnt_r;
    logic                   fifo_ivalid_r;
    logic [DATA_WIDTH-1:0]  fifo_idata_r;

    logic                   any_valid_s;
    logic [ID_W-1:0]        pick_s;
    logic                   cur_valid_s;
    logic [DATA_WIDTH-1:0]  cur_data_s;
    logic                   beat_s;
    logic                   last_beat_s;

    // First requester with valid set, searching upward from p+1 with wrap.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    p);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = p;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (!found && v[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_valid_s = |req_valid;
    assign pick_s      = rr_pick(req_valid, ptr_r);

    // Select valid and data of the currently granted requester.
    always_comb begin
        cur_valid_s = 1'b0;
        cur_data_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_r == ID_W'(i)) begin
                cur_valid_s = req_valid[i];
                cur_data_s  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                cur_valid_s = cur_valid_s;
                cur_data_s  = cur_data_s;
            end
        end
    end

    // A beat is only ever accepted while the FIFO reports room.
    assign beat_s      = (state_r == GRANT) && cur_valid_s && fifo_iready;
    assign last_beat_s = beat_s && (beat_cnt_r == CNT_W'(MAX_BURST - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: burst ends on the last allowed beat or when the
    // granted requester drops valid; a throttled stall keeps the grant.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_next_s = GRANT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT: begin
                if (last_beat_s || !cur_valid_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GRANT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode: only the granted requester sees the FIFO iready.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready = '0;
                busy      = 1'b0;
            end
            GRANT: begin
                busy = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_id_r == ID_W'(i)) begin
                        req_ready[i] = fifo_iready;
                    end else begin
                        req_ready[i] = 1'b0;
                    end
                end
            end
            default: begin
                req_ready = '0;
                busy      = 1'b0;
            end
        endcase
    end

    // Grant bookkeeping and registered FIFO write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r         <= ID_W'(NUM_REQ - 1);
            grant_id_r    <= '0;
            beat_cnt_r    <= '0;
            fifo_ivalid_r <= 1'b0;
            fifo_idata_r  <= '0;
        end else begin
            fifo_ivalid_r <= beat_s;
            if (beat_s) begin
                fifo_idata_r <= cur_data_s;
            end else begin
                fifo_idata_r <= fifo_idata_r;
            end
            if ((state_r == IDLE) && any_valid_s) begin
                grant_id_r <= pick_s;
                ptr_r      <= pick_s;
                beat_cnt_r <= '0;
            end else if (beat_s) begin
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    assign fifo_ivalid = fifo_ivalid_r;
    assign fifo_idata  = fifo_idata_r;
    assign grant_id    = grant_id_r;

`ifdef SYNC_FIFO_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] beat_count_r;

    // Per-requester accepted-beat counters, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (beat_s && (grant_id_r == ID_W'(i)) &&
                    (beat_count_r[i*16 +: 16] != 16'hFFFF)) begin
                    beat_count_r[i*16 +: 16] <= beat_count_r[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign beat_count = beat_count_r;
`endif

endmodule

// File: doc/sync_fifo_rr_arbiter.md
# sync_fifo_rr_arbiter

Round-robin write-side arbiter that shares one `sync_fifo` input port among `NUM_REQ` valid/ready requesters inside the user project.
- Grants one requester at a time for a burst of at most `MAX_BURST` beats.
- Throttles on the FIFO's registered `iready` threshold.
- Drives the FIFO's unconditional `ivalid` write strobe from a register, one beat per cycle.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: beat width; must equal the FIFO `DATA_WIDTH`.
- `MAX_BURST`, 4: maximum beats per grant, ≥1.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in `NUM_REQ`: per-requester beat valid.
- `req_ready` out `NUM_REQ`: per-requester accept; combinational.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `fifo_ivalid` out 1: registered write strobe to the FIFO `ivalid`.
- `fifo_idata` out `DATA_WIDTH`: registered write data to the FIFO `idata`.
- `fifo_iready` in 1: FIFO `iready`, below-threshold indication.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `busy` out 1: high in GRANT.

## Operation
- FSM states: IDLE, GRANT. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` bit is high, select the first set index searching from `ptr+1` upward, modulo `NUM_REQ`.
  - Load `grant_id`, set `ptr` to that index, clear `beat_cnt`, go to GRANT.
  - If no `req_valid` bit is high, stay in IDLE.
- **GRANT**
  - `req_ready[grant_id] = fifo_iready`; all other `req_ready` bits are 0.
  - A beat transfers when `req_valid[grant_id] & req_ready[grant_id]`.
  - On a beat:
    - Next cycle `fifo_ivalid` = 1 and `fifo_idata` = that requester's slice.
    - `beat_cnt` increments.
  - With no beat, `fifo_ivalid` = 0 next cycle and `fifo_idata` holds its last value.
- **Exit GRANT → IDLE** when either:
  - a beat occurs with `beat_cnt == MAX_BURST-1`, or
  - `req_valid[grant_id]` is 0 in a cycle.
- A low `fifo_iready` with `req_valid` high stalls in GRANT and does not release.
- In IDLE, `req_ready` is all 0 and `fifo_ivalid` is 0 the following cycle.
- Widths:
  - `beat_cnt` is `$clog2(MAX_BURST+1)` bits.
  - `ptr` is `$clog2(NUM_REQ)` bits.
  - The pointer wraps from `NUM_REQ-1` to 0.
- FIFO overrun safety:
  - Writes are at most one per cycle, one cycle after the `fifo_iready` sample.
  - The FIFO's `FULL_THRES < FIFO_DEPTH` slack absorbs the in-flight beat.
  - The arbiter never asserts a beat accept while `fifo_iready` = 0.

## Timing
- Reset values:
  - `fifo_ivalid` = 0, `fifo_idata` = 0, `grant_id` = 0, `busy` = 0, `req_ready` = 0.
  - `ptr` = `NUM_REQ-1`, so requester 0 has first priority.
- Grant latency: `req_valid` seen in IDLE at cycle N → `busy` and `req_ready` at N+1 (if `fifo_iready`) → `fifo_ivalid` at N+2.
- Throughput: 1 beat/cycle within a burst. Every grant boundary costs exactly one IDLE cycle with no beat.
- Simultaneous requests resolve by rotating priority only. There is no fixed-priority fallback.
- Reset asserted mid-burst:
  - All outputs return to reset values immediately.
  - A beat registered but not yet presented is dropped.
  - A requester-side handshake that completed before reset counts as delivered to the arbiter only.

## Configuration
- `SYNC_FIFO_ARB_STATS_EN`
  - **Defined:** adds output `beat_count` (`NUM_REQ*16` bits): per-requester 16-bit beat counters.
    - Each counter increments on every accepted beat of its requester.
    - Counters saturate at 16'hFFFF.
    - Reset to 0.
  - **Undefined:** the port and counters are absent. All other behaviour is identical.

## Test plan
- **Single burst split:** `MAX_BURST`=4, requester 1 holds `req_valid` for 6 beats with data 0x10–0x15, `fifo_iready`=1.
  - `fifo_idata` = 0x10–0x13 on 4 consecutive cycles.
  - Then a 1-cycle gap.
  - Then 0x14, 0x15.
  - `grant_id` = 1 throughout.
- **Round-robin order:** all 4 requesters valid continuously.
  - Grants go 0,1,2,3,0, with 4 beats each and one idle cycle between grants.
  - No requester is granted twice before the others.
- **FIFO throttle:** drop `fifo_iready` for 3 cycles mid-burst.
  - `req_ready` = 0 and `fifo_ivalid` = 0 for those cycles (offset by 1 cycle for `fifo_ivalid`).
  - `fifo_idata` holds its last value.
  - The burst resumes without losing or duplicating a beat; total beats = 4.
- **Early release:** requester 2 drops `req_valid` after 2 beats while requester 3 is valid.
  - GRANT exits.
  - The next grant is 3, after one IDLE cycle.
- **Reset mid-burst:** assert `rst_n`=0 during beat 2.
  - Outputs go to reset values asynchronously.
  - After release, the first grant goes to requester 0 when all requesters are valid.
- **Stats** (with `SYNC_FIFO_ARB_STATS_EN`):
  - 70000 beats from requester 0 → `beat_count[15:0]` = 16'hFFFF.
  - The other counters stay 0.
